control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Moore FSM that sequences the 32-bit datapath: fetch, decode on IR[31:27], execute in T-steps.
//  Drives every datapath strobe (register in/out, Gra/Grb/Grc, ALU op, memory read/write, I/O).
//  Sits beside the datapath; its only inputs from it are IR and the conff branch flag.
// PARAMETERS
//  IR_W    32  instruction register width
//  OP_MSB  31  top bit of opcode field; opcode = IR[OP_MSB -: 5]
// PORTS
//  clk         in   1   system clock, rising edge
//  clear       in   1   synchronous active-high reset, shared with datapath
//  IR          in   32  instruction register contents
//  CON         in   1   conff_logic branch-condition output
//  stop        in   1   halt request, sampled only on instruction boundary
//  mem_ready   in   1   memory handshake, used only with CU_MEM_WAIT_EN
//  PCout,MDRout,Zhighout,Zlowout,HIout,LOout,Inportout,Cout,BAout  out 1 each  bus source selects
//  PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,CONin,OutPort  out 1 each  register load enables
//  Gra,Grb,Grc,Rin,Rout  out 1 each  Sel_Enc controls
//  AND,OR,ADD,SUB,MUL,DIV,SHR,SHL,ROR,ROL,NEG,NOT,IncPC  out 1 each  one-hot ALU op
//  read,write  out 1   memory strobes
//  run         out 1   high while executing; low in RESET/HALT
//  illegal     out 1   sticky: unknown opcode decoded
// BEHAVIOUR
//  Reset: clear high at edge -> state RESET; all outputs 0, illegal 0. Next edge -> T0. clear wins over all.
//  Outputs: function of state only, except BR_T6 (uses CON). At most one bus source and one ALU op per state.
//  Fetch: T0 PCout,MARin,IncPC,Zin | T1 Zlowout,PCin,read,MDRin | T2 MDRout,IRin.
//  T3+ by opcode:
//   00011-01010 add,sub,shr,shl,ror,rol,and,or: T3 Grb,Rout,Yin | T4 Grc,Rout,op,Zin | T5 Zlowout,Gra,Rin.
//   01011-01101 addi,andi,ori: as above, T4 uses Cout instead of Grc,Rout.
//   01110/01111 mul/div: T3 Gra,Rout,Yin | T4 Grb,Rout,op,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin.
//   10000/10001 neg/not: T3 Grb,Rout,op,Zin | T4 Zlowout,Gra,Rin.
//   00000 ld: T3 Grb,BAout,Yin | T4 Cout,ADD,Zin | T5 Zlowout,MARin | T6 read,MDRin | T7 MDRout,Gra,Rin.
//   00001 ldi: T3,T4 as ld | T5 Zlowout,Gra,Rin.
//   00010 st: T3-T5 as ld | T6 Gra,Rout,MDRin | T7 write.
//   10010 br: T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,ADD,Zin | T6 Zlowout,PCin only if CON=1.
//   10011 jr: T3 Gra,Rout,PCin.   10100 jal: T3 PCout,Grb,Rin | T4 Gra,Rout,PCin.
//   10101 in: T3 Inportout,Gra,Rin.  10110 out: T3 Gra,Rout,OutPort.
//   10111 mfhi: T3 HIout,Gra,Rin.    11000 mflo: T3 LOout,Gra,Rin.
//   11001 nop: T2 -> T0.   11010 halt: -> HALT.   11011-11111: set illegal, treat as nop.
//  Last step of each instruction -> T0, unless stop=1 that cycle -> HALT.
//  HALT: all strobes 0, run 0; leaves only via clear.
//  clear mid-instruction: abort; no partial write/PCin after the reset edge.
//  IR decoded only in T2->T3 transition; later IR changes ignored until next T2.
// CONFIGURATION
//  CU_MEM_WAIT_EN defined: T1, ld T6, st T7 hold (strobes asserted) until mem_ready=1, then advance.
//  Undefined: mem_ready ignored; every memory step is exactly one cycle.
// TESTING
//  clear 1 cycle, IR=add -> RESET then T0 with PCout,MARin,IncPC,Zin; run=1; add done in 6 cycles.
//  ld (IR=0x00800055) -> T6 read,MDRin; T7 MDRout,Gra,Rin; back at T0 after 8 cycles.
//  br, CON=0 -> T6 has no PCin; CON=1 -> T6 Zlowout,PCin; both return to T0 after 7 cycles.
//  mul -> T5 Zlowout,LOin then T6 Zhighout,HIin; exactly one ALU op high in T4 (MUL).
//  opcode 11100 -> illegal=1, next instruction fetched; halt or stop=1 at end of add -> HALT, run=0 until clear.
//  CU_MEM_WAIT_EN, mem_ready low 3 cycles in T1 -> read,MDRin held 4 cycles, T2 one cycle later.

Source files
------------

// File: rtl/control_unit_if.sv
// Datapath-facing signal bundle of the control unit.
// The master side (the control unit) receives IR, CON, stop and mem_ready,
// and drives every datapath strobe plus the run/illegal status.
interface control_unit_if #(
  parameter int IR_W = 32
);
  logic [IR_W-1:0] IR;
  logic CON, stop, mem_ready;
  // bus source selects
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout;
  // register load enables
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort;
  // register-file select controls
  logic Gra, Grb, Grc, Rin, Rout;
  // one-hot ALU operation
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  // memory strobes and status
  logic read, write, run, illegal;

  modport master (
    input  IR, CON, stop, mem_ready,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort,
    output Gra, Grb, Grc, Rin, Rout,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    output read, write, run, illegal
  );

  modport slave (
    output IR, CON, stop, mem_ready,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPort,
    input  Gra, Grb, Grc, Rin, Rout,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    input  read, write, run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the 32-bit datapath: fetch (T0-T2), decode of IR[31:27]
// on the T2->T3 edge, then per-opcode execute steps T3..T7.
// Optional build macro: CU_MEM_WAIT_EN -- memory steps (T1, ld T6, st T7) hold
// with their strobes asserted until mem_ready is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RESET | clear seen; all strobes low, run low
// S_T0    | fetch: PC to MAR, PC+1 into Z
// S_T1    | fetch: PC update, memory read into MDR
// S_T2    | fetch: MDR to IR; opcode latched on leaving this state
// S_T3-T7 | execute steps, meaning depends on latched opcode
// S_HALT  | stopped; strobes low, run low; left only via clear
module control_unit #(
  parameter int IR_W   = 32,
  parameter int OP_MSB = 31
) (
  input logic clk,
  input logic clear,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    F_NONE, F_AND, F_OR, F_ADD, F_SUB, F_MUL, F_DIV,
    F_SHR, F_SHL, F_ROR, F_ROL, F_NEG, F_NOT
  } alu_fn_t;

  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_LDI    = 5'b00001;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_SHR    = 5'b00101;
  localparam logic [4:0] OP_SHL    = 5'b00110;
  localparam logic [4:0] OP_ROR    = 5'b00111;
  localparam logic [4:0] OP_ROL    = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01001;
  localparam logic [4:0] OP_OR     = 5'b01010;
  localparam logic [4:0] OP_ADDI   = 5'b01011;
  localparam logic [4:0] OP_ANDI   = 5'b01100;
  localparam logic [4:0] OP_ORI    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_NEG    = 5'b10000;
  localparam logic [4:0] OP_NOT    = 5'b10001;
  localparam logic [4:0] OP_BR     = 5'b10010;
  localparam logic [4:0] OP_JR     = 5'b10011;
  localparam logic [4:0] OP_JAL    = 5'b10100;
  localparam logic [4:0] OP_IN     = 5'b10101;
  localparam logic [4:0] OP_OUT    = 5'b10110;
  localparam logic [4:0] OP_MFHI   = 5'b10111;
  localparam logic [4:0] OP_MFLO   = 5'b11000;
  localparam logic [4:0] OP_NOP    = 5'b11001;
  localparam logic [4:0] OP_HALT   = 5'b11010;
  localparam logic [4:0] OP_ILL_LO = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic       illegal_q;
  logic [4:0] ir_op;
  logic       mem_step;
  logic       mem_go;
  logic       unused_ok;
  alu_fn_t    alu_fn;

  assign ir_op = cu.IR[OP_MSB -: 5];

`ifdef CU_MEM_WAIT_EN
  assign mem_go    = cu.mem_ready;
  assign unused_ok = ^cu.IR[IR_W-1:0];
`else
  assign mem_go    = 1'b1;
  assign unused_ok = ^{cu.IR[IR_W-1:0], cu.mem_ready};
`endif

  // ALU function selected by an arithmetic/logic opcode
  function automatic alu_fn_t op_fn(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: op_fn = F_ADD;
      OP_SUB:          op_fn = F_SUB;
      OP_SHR:          op_fn = F_SHR;
      OP_SHL:          op_fn = F_SHL;
      OP_ROR:          op_fn = F_ROR;
      OP_ROL:          op_fn = F_ROL;
      OP_AND, OP_ANDI: op_fn = F_AND;
      OP_OR, OP_ORI:   op_fn = F_OR;
      OP_MUL:          op_fn = F_MUL;
      OP_DIV:          op_fn = F_DIV;
      OP_NEG:          op_fn = F_NEG;
      OP_NOT:          op_fn = F_NOT;
      default:         op_fn = F_NONE;
    endcase
  endfunction

  // Final execute step of each instruction that reaches T3
  function automatic state_t last_step(input logic [4:0] op);
    case (op) inside
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  last_step = S_T3;
      OP_JAL, OP_NEG, OP_NOT:                  last_step = S_T4;
      [OP_ADD:OP_ORI], OP_LDI:                 last_step = S_T5;
      OP_MUL, OP_DIV, OP_BR:                   last_step = S_T6;
      OP_LD, OP_ST:                            last_step = S_T7;
      default:                                 last_step = S_T3;
    endcase
  endfunction

  // Following execute step
  function automatic state_t next_t(input state_t s);
    case (s)
      S_T3:    next_t = S_T4;
      S_T4:    next_t = S_T5;
      S_T5:    next_t = S_T6;
      S_T6:    next_t = S_T7;
      default: next_t = S_T0;
    endcase
  endfunction

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_RESET;
      op_q      <= OP_NOP;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) begin
        op_q <= ir_op;
        if (ir_op >= OP_ILL_LO) illegal_q <= 1'b1;
      end
    end
  end

  // Next-state: fetch, decode dispatch, execute sequencing and memory holds
  always_comb begin
    state_d  = state_q;
    mem_step = 1'b0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1: begin
        mem_step = 1'b1;
        state_d  = S_T2;
      end
      S_T2: begin
        if (ir_op == OP_HALT)
          state_d = S_HALT;
        else if (ir_op == OP_NOP || ir_op >= OP_ILL_LO)
          state_d = cu.stop ? S_HALT : S_T0;
        else
          state_d = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        mem_step = (state_q == S_T6 && op_q == OP_LD) ||
                   (state_q == S_T7 && op_q == OP_ST);
        if (state_q == last_step(op_q))
          state_d = cu.stop ? S_HALT : S_T0;
        else
          state_d = next_t(state_q);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (mem_step && !mem_go) state_d = state_q;
  end

  // Strobes: decoded from state and latched opcode (CON used only in br T6)
  always_comb begin
    cu.PCout = 1'b0; cu.MDRout = 1'b0; cu.Zhighout = 1'b0; cu.Zlowout = 1'b0;
    cu.HIout = 1'b0; cu.LOout = 1'b0; cu.Inportout = 1'b0; cu.Cout = 1'b0;
    cu.BAout = 1'b0;
    cu.PCin = 1'b0; cu.IRin = 1'b0; cu.MARin = 1'b0; cu.MDRin = 1'b0;
    cu.Yin = 1'b0; cu.Zin = 1'b0; cu.HIin = 1'b0; cu.LOin = 1'b0;
    cu.CONin = 1'b0; cu.OutPort = 1'b0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0; cu.Rin = 1'b0; cu.Rout = 1'b0;
    cu.AND = 1'b0; cu.OR = 1'b0; cu.ADD = 1'b0; cu.SUB = 1'b0; cu.MUL = 1'b0;
    cu.DIV = 1'b0; cu.SHR = 1'b0; cu.SHL = 1'b0; cu.ROR = 1'b0; cu.ROL = 1'b0;
    cu.NEG = 1'b0; cu.NOT = 1'b0; cu.IncPC = 1'b0;
    cu.read = 1'b0; cu.write = 1'b0;
    alu_fn = F_NONE;

    case (state_q)
      S_T0: begin
        cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1;
      end
      S_T1: begin
        cu.Zlowout = 1'b1; cu.PCin = 1'b1; cu.read = 1'b1; cu.MDRin = 1'b1;
      end
      S_T2: begin
        cu.MDRout = 1'b1; cu.IRin = 1'b1;
      end
      S_T3: begin
        case (op_q) inside
          [OP_ADD:OP_ORI]:      begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          OP_MUL, OP_DIV:       begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          OP_NEG, OP_NOT: begin
            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; alu_fn = op_fn(op_q);
          end
          OP_LD, OP_LDI, OP_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
          OP_BR:                begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          OP_JR:                begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          OP_JAL:               begin cu.PCout = 1'b1; cu.Grb = 1'b1; cu.Rin = 1'b1; end
          OP_IN:                begin cu.Inportout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_OUT:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPort = 1'b1; end
          OP_MFHI:              begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_MFLO:              begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_q) inside
          [OP_ADD:OP_OR]: begin
            cu.Grc = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; alu_fn = op_fn(op_q);
          end
          [OP_ADDI:OP_ORI]: begin
            cu.Cout = 1'b1; cu.Zin = 1'b1; alu_fn = op_fn(op_q);
          end
          OP_MUL, OP_DIV: begin
            cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; alu_fn = op_fn(op_q);
          end
          OP_NEG, OP_NOT:       begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_LD, OP_LDI, OP_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; alu_fn = F_ADD; end
          OP_BR:                begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
          OP_JAL:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_q) inside
          [OP_ADD:OP_ORI], OP_LDI: begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_MUL, OP_DIV:          begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
          OP_LD, OP_ST:            begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
          OP_BR:                   begin cu.Cout = 1'b1; cu.Zin = 1'b1; alu_fn = F_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_q)
          OP_MUL, OP_DIV: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
          OP_LD:          begin cu.read = 1'b1; cu.MDRin = 1'b1; end
          OP_ST:          begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
          OP_BR: begin
            // branch taken only when the condition register says so
            if (cu.CON) begin cu.Zlowout = 1'b1; cu.PCin = 1'b1; end
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_q)
          OP_LD:   begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_ST:   cu.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    case (alu_fn)
      F_AND:   cu.AND = 1'b1;
      F_OR:    cu.OR  = 1'b1;
      F_ADD:   cu.ADD = 1'b1;
      F_SUB:   cu.SUB = 1'b1;
      F_MUL:   cu.MUL = 1'b1;
      F_DIV:   cu.DIV = 1'b1;
      F_SHR:   cu.SHR = 1'b1;
      F_SHL:   cu.SHL = 1'b1;
      F_ROR:   cu.ROR = 1'b1;
      F_ROL:   cu.ROL = 1'b1;
      F_NEG:   cu.NEG = 1'b1;
      F_NOT:   cu.NOT = 1'b1;
      default: ;
    endcase
  end

  assign cu.run     = (state_q != S_RESET) && (state_q != S_HALT);
  assign cu.illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: random instruction stream checked against a
// micro-operation table that lists, per opcode, the strobe set of every cycle.
module tb_control_unit;

  typedef logic [38:0] vec_t;

  localparam vec_t M_PCOUT = 39'd1 << 0,  M_MDROUT = 39'd1 << 1,  M_ZHIGH  = 39'd1 << 2;
  localparam vec_t M_ZLOW  = 39'd1 << 3,  M_HIOUT  = 39'd1 << 4,  M_LOOUT  = 39'd1 << 5;
  localparam vec_t M_INPT  = 39'd1 << 6,  M_COUT   = 39'd1 << 7,  M_BAOUT  = 39'd1 << 8;
  localparam vec_t M_PCIN  = 39'd1 << 9,  M_IRIN   = 39'd1 << 10, M_MARIN  = 39'd1 << 11;
  localparam vec_t M_MDRIN = 39'd1 << 12, M_YIN    = 39'd1 << 13, M_ZIN    = 39'd1 << 14;
  localparam vec_t M_HIIN  = 39'd1 << 15, M_LOIN   = 39'd1 << 16, M_CONIN  = 39'd1 << 17;
  localparam vec_t M_OUTP  = 39'd1 << 18, M_GRA    = 39'd1 << 19, M_GRB    = 39'd1 << 20;
  localparam vec_t M_GRC   = 39'd1 << 21, M_RIN    = 39'd1 << 22, M_ROUT   = 39'd1 << 23;
  localparam vec_t M_AND   = 39'd1 << 24, M_OR     = 39'd1 << 25, M_ADD    = 39'd1 << 26;
  localparam vec_t M_SUB   = 39'd1 << 27, M_MUL    = 39'd1 << 28, M_DIV    = 39'd1 << 29;
  localparam vec_t M_SHR   = 39'd1 << 30, M_SHL    = 39'd1 << 31, M_ROR    = 39'd1 << 32;
  localparam vec_t M_ROL   = 39'd1 << 33, M_NEG    = 39'd1 << 34, M_NOT    = 39'd1 << 35;
  localparam vec_t M_INCPC = 39'd1 << 36, M_READ   = 39'd1 << 37, M_WRITE  = 39'd1 << 38;

  localparam vec_t FETCH0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;

  logic clk = 1'b0;
  logic clear;
  int   tests = 0;
  int   failed = 0;
  bit   ill_model = 1'b0;
  vec_t exp_q[$];
  bit   mem_q[$];
  vec_t obs;

  control_unit_if #(.IR_W(32)) ifc ();
  control_unit dut (.clk(clk), .clear(clear), .cu(ifc));

  always #5 clk = ~clk;

  assign obs = {ifc.write, ifc.read, ifc.IncPC, ifc.NOT, ifc.NEG, ifc.ROL, ifc.ROR,
                ifc.SHL, ifc.SHR, ifc.DIV, ifc.MUL, ifc.SUB, ifc.ADD, ifc.OR, ifc.AND,
                ifc.Rout, ifc.Rin, ifc.Grc, ifc.Grb, ifc.Gra,
                ifc.OutPort, ifc.CONin, ifc.LOin, ifc.HIin, ifc.Zin, ifc.Yin,
                ifc.MDRin, ifc.MARin, ifc.IRin, ifc.PCin,
                ifc.BAout, ifc.Cout, ifc.Inportout, ifc.LOout, ifc.HIout,
                ifc.Zlowout, ifc.Zhighout, ifc.MDRout, ifc.PCout};

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic vec_t alu_mask(input logic [4:0] op);
    case (op)
      5'd3, 5'd11: return M_ADD;
      5'd4:        return M_SUB;
      5'd5:        return M_SHR;
      5'd6:        return M_SHL;
      5'd7:        return M_ROR;
      5'd8:        return M_ROL;
      5'd9, 5'd12: return M_AND;
      5'd10, 5'd13: return M_OR;
      5'd14:       return M_MUL;
      5'd15:       return M_DIV;
      5'd16:       return M_NEG;
      5'd17:       return M_NOT;
      default:     return '0;
    endcase
  endfunction

  function automatic void push(input vec_t v, input bit m);
    exp_q.push_back(v);
    mem_q.push_back(m);
  endfunction

  // micro-operation table: one entry per cycle from T0 to the last step
  function automatic void build(input logic [4:0] op, input logic con_v);
    vec_t a;
    a = alu_mask(op);
    exp_q.delete();
    mem_q.delete();
    push(FETCH0, 0);
    push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 1);
    push(M_MDROUT | M_IRIN, 0);
    if (op >= 5'd3 && op <= 5'd10) begin
      push(M_GRB | M_ROUT | M_YIN, 0); push(M_GRC | M_ROUT | a | M_ZIN, 0);
      push(M_ZLOW | M_GRA | M_RIN, 0);
    end else if (op >= 5'd11 && op <= 5'd13) begin
      push(M_GRB | M_ROUT | M_YIN, 0); push(M_COUT | a | M_ZIN, 0);
      push(M_ZLOW | M_GRA | M_RIN, 0);
    end else if (op == 5'd14 || op == 5'd15) begin
      push(M_GRA | M_ROUT | M_YIN, 0); push(M_GRB | M_ROUT | a | M_ZIN, 0);
      push(M_ZLOW | M_LOIN, 0); push(M_ZHIGH | M_HIIN, 0);
    end else if (op == 5'd16 || op == 5'd17) begin
      push(M_GRB | M_ROUT | a | M_ZIN, 0); push(M_ZLOW | M_GRA | M_RIN, 0);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 0); push(M_COUT | M_ADD | M_ZIN, 0);
      if (op == 5'd1) push(M_ZLOW | M_GRA | M_RIN, 0);
      else push(M_ZLOW | M_MARIN, 0);
      if (op == 5'd0) begin push(M_READ | M_MDRIN, 1); push(M_MDROUT | M_GRA | M_RIN, 0); end
      if (op == 5'd2) begin push(M_GRA | M_ROUT | M_MDRIN, 0); push(M_WRITE, 1); end
    end else if (op == 5'd18) begin
      push(M_GRA | M_ROUT | M_CONIN, 0); push(M_PCOUT | M_YIN, 0);
      push(M_COUT | M_ADD | M_ZIN, 0); push(con_v ? (M_ZLOW | M_PCIN) : '0, 0);
    end else if (op == 5'd19) push(M_GRA | M_ROUT | M_PCIN, 0);
    else if (op == 5'd20) begin
      push(M_PCOUT | M_GRB | M_RIN, 0); push(M_GRA | M_ROUT | M_PCIN, 0);
    end
    else if (op == 5'd21) push(M_INPT | M_GRA | M_RIN, 0);
    else if (op == 5'd22) push(M_GRA | M_ROUT | M_OUTP, 0);
    else if (op == 5'd23) push(M_HIOUT | M_GRA | M_RIN, 0);
    else if (op == 5'd24) push(M_LOOUT | M_GRA | M_RIN, 0);
  endfunction

  task automatic chk_cycle(input string tag, input vec_t want);
    check({tag, " strobes"}, 64'(obs), 64'(want));
    check({tag, " run"}, 64'(ifc.run), 64'd1);
    check({tag, " illegal"}, 64'(ifc.illegal), 64'(ill_model));
  endtask

  task automatic chk_halt(input string tag);
    for (int j = 0; j < 4; j++) begin
      check({tag, " halt strobes"}, 64'(obs), 64'd0);
      check({tag, " halt run"}, 64'(ifc.run), 64'd0);
      check({tag, " halt illegal"}, 64'(ifc.illegal), 64'(ill_model));
      if (j < 3) begin
        ifc.IR = $urandom; ifc.stop = 1'($urandom); ifc.CON = 1'($urandom);
        ifc.mem_ready = 1'($urandom);
        step();
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    ifc.IR = {5'd3, 27'($urandom)};
    step();
    ill_model = 1'b0;
    check("reset strobes", 64'(obs), 64'd0);
    check("reset run", 64'(ifc.run), 64'd0);
    check("reset illegal", 64'(ifc.illegal), 64'd0);
    clear = 1'b0;
    ifc.stop = 1'b0;
    ifc.mem_ready = 1'b1;
    step();
    chk_cycle("after reset T0", FETCH0);
  endtask

  // Runs one instruction starting in T0; leaves the bench in the following T0 or HALT.
  task automatic run_instr(input logic [31:0] ir, input logic con_v, input bit stop_req, input int w);
    logic [4:0] op;
    string tag;
    op = ir[31:27];
    build(op, con_v);
    ifc.IR = ir;
    ifc.CON = con_v;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      if (i >= 3) ifc.IR = $urandom;
      tag = $sformatf("op%0d c%0d", op, i);
      if (mem_q[i]) begin
        ifc.mem_ready = (w == 0);
`ifdef CU_MEM_WAIT_EN
        for (int k = 0; k < w; k++) begin
          chk_cycle({tag, " hold"}, exp_q[i]);
          step();
        end
        ifc.mem_ready = 1'b1;
`endif
      end
      ifc.stop = (i == exp_q.size() - 1) ? stop_req : 1'($urandom_range(0, 1));
      chk_cycle(tag, exp_q[i]);
    end
    step();
    ifc.stop = 1'b0;
    if (op >= 5'd27) ill_model = 1'b1;
    if (stop_req || op == 5'd26) chk_halt($sformatf("op%0d", op));
    else chk_cycle($sformatf("op%0d next T0", op), FETCH0);
  endtask

  // Asserts clear while in cycle k of an instruction; nothing may leak past the reset edge.
  task automatic abort_at(input logic [31:0] ir, input int k);
    build(ir[31:27], 1'b1);
    ifc.IR = ir; ifc.CON = 1'b1; ifc.mem_ready = 1'b1; ifc.stop = 1'b0;
    for (int i = 0; i <= k; i++) begin
      if (i > 0) step();
      if (i >= 3) ifc.IR = $urandom;
      chk_cycle($sformatf("abort op%0d c%0d", ir[31:27], i), exp_q[i]);
    end
    do_clear();
  endtask

  initial begin
    int r;
    clear = 1'b1;
    ifc.IR = '0; ifc.CON = 1'b0; ifc.stop = 1'b0; ifc.mem_ready = 1'b1;
    do_clear();

    run_instr({5'd3, 27'($urandom)}, 1'b0, 1'b0, 0);
    run_instr(32'h0080_0055, 1'b0, 1'b0, 0);
    run_instr({5'd18, 27'($urandom)}, 1'b0, 1'b0, 0);
    run_instr({5'd18, 27'($urandom)}, 1'b1, 1'b0, 0);
    run_instr({5'd14, 27'($urandom)}, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 30));
      if (r >= 26) r = r + 1;
      run_instr({5'(r), 27'($urandom)}, 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
    end

    do_clear();
    run_instr({5'b11100, 27'($urandom)}, 1'b0, 1'b0, 0);
    run_instr({5'd3, 27'($urandom)}, 1'b0, 1'b0, 0);
    run_instr({5'd3, 27'($urandom)}, 1'b0, 1'b1, 0);
    do_clear();

    run_instr({5'd2, 27'($urandom)}, 1'b0, 1'b0, 0);
    run_instr({5'd26, 27'($urandom)}, 1'b0, 1'b0, 0);
    do_clear();

    run_instr({5'd25, 27'($urandom)}, 1'b0, 1'b1, 0);
    do_clear();

    run_instr({5'd0, 27'($urandom)}, 1'b0, 1'b0, 3);
    run_instr({5'd2, 27'($urandom)}, 1'b0, 1'b1, 2);
    do_clear();

    abort_at({5'd2, 27'($urandom)}, 7);
    abort_at({5'd0, 27'($urandom)}, 6);
    abort_at({5'd18, 27'($urandom)}, 5);
    run_instr({5'd20, 27'($urandom)}, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
